// File: rtl/shiftreg_sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module      : shiftreg_sipo_deframer
// Description : Serial-in, parallel-out receiver. Assembles WIDTH-bit words
//               from an MSB-first serial stream, aligned by a start strobe on
//               the MSB, and queues completed words in a small output FIFO
//               with a valid/ready handshake.
// Ports       :
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   sin        in   1         serial data, MSB first
//   start      in   1         high in the cycle the MSB of a word is on sin
//   dout       out  WIDTH     head-of-FIFO word (valid while dout_valid=1)
//   dout_valid out  1         FIFO non-empty
//   dout_ready in   1         consumer accepts dout when valid & ready
//   level      out  LW        FIFO occupancy 0..DEPTH
//   busy       out  1         word assembly in progress
//   overflow   out  1         sticky: completed word dropped (FIFO full)
//   frame_err  out  1         sticky: start arrived mid-word
//   clr_err    in   1         clears both sticky flags on the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module shiftreg_sipo_deframer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sin,
  input  logic                     start,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     clr_err
);

  // Bit counter only has to reach WIDTH-1.
  localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int c_aw    = $clog2(DEPTH);

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_first = c_cnt_w'(1);
  localparam logic [c_aw:0]      c_lvl_full  = (c_aw + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Deserializer state
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_shreg;
  logic                 r_push;

  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]     w_shreg_nxt;
  logic                 w_push_nxt;
  logic                 w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_push  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_push  <= w_push_nxt;
    end
  end

  // The MSB is loaded into bit 0; the WIDTH-1 following shifts walk it up to
  // bit WIDTH-1, so the register is word-aligned exactly on the LSB sample.
  // After completion r_shreg holds the word for one cycle while r_push is
  // high; a start in that same cycle overwrites it only at the edge where the
  // FIFO captures the old value, so back-to-back words need no gap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_push_nxt  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_shreg_nxt = {{(WIDTH-1){1'b0}}, sin};
          w_cnt_nxt   = c_cnt_first;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          // Restart: the partial word is thrown away and this bit is the
          // MSB of the new word.
          w_abort     = 1'b1;
          w_shreg_nxt = {{(WIDTH-1){1'b0}}, sin};
          w_cnt_nxt   = c_cnt_first;
        end else begin
          w_shreg_nxt = {r_shreg[WIDTH-2:0], sin};
          if (r_cnt == c_cnt_last) begin
            w_push_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (r_state == ST_SHIFT);

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_level;

  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_drop;

  assign w_pop     = dout_valid & dout_ready;
  assign w_full    = (r_level == c_lvl_full);
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = r_push & (~w_full | w_pop);
  assign w_drop    = r_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wptr] <= r_shreg;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout       = r_mem[r_rptr];
  assign dout_valid = (r_level != '0);
  assign level      = r_level;

  // --------------------------------------------------------------------------
  // Sticky error flags: a new event in the clear cycle keeps the flag set.
  // --------------------------------------------------------------------------
  logic r_overflow;
  logic r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_abort) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shiftreg_sipo_deframer
// Description : Self-checking bench for shiftreg_sipo_deframer: directed
//               scenarios followed by randomized traffic, all compared every
//               cycle against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shiftreg_sipo_deframer;

  localparam int W  = 16;
  localparam int D  = 2;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sin;
  logic          start;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [LW-1:0] level;
  logic          busy;
  logic          overflow;
  logic          frame_err;
  logic          clr_err;

  always #5 clk = ~clk;

  shiftreg_sipo_deframer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .start      (start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .busy       (busy),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_nbits;       // bits of the current word collected so far (0 = idle)
  int unsigned  m_acc;         // value accumulated from those bits
  bit           m_pend;        // a completed word is waiting to enter the FIFO
  logic [W-1:0] m_pend_word;
  logic [W-1:0] m_q[$];
  bit           m_ovf;
  bit           m_ferr;

  function automatic void model_reset();
    m_nbits = 0;
    m_acc   = 0;
    m_pend  = 1'b0;
    m_pend_word = '0;
    m_q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endfunction

  function automatic void model_step(input bit st, input bit s, input bit rdy, input bit clr);
    bit drop  = 1'b0;
    bit abort = 1'b0;
    bit npend = 1'b0;
    logic [W-1:0] nword = '0;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < D) m_q.push_back(m_pend_word);
      else drop = 1'b1;
    end
    if (st) begin
      if (m_nbits != 0) abort = 1'b1;
      m_acc   = int'(s);
      m_nbits = 1;
    end else if (m_nbits != 0) begin
      m_acc   = m_acc * 2 + int'(s);
      m_nbits = m_nbits + 1;
      if (m_nbits == W) begin
        npend   = 1'b1;
        nword   = W'(m_acc);
        m_nbits = 0;
      end
    end
    m_pend      = npend;
    m_pend_word = nword;
    m_ovf  = drop  ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_ferr = abort ? 1'b1 : (clr ? 1'b0 : m_ferr);
  endfunction

  task automatic check_outputs();
    check_eq("dout_valid", dout_valid, m_q.size() != 0);
    check_eq("level", level, m_q.size());
    if (m_q.size() != 0) check_eq("dout", dout, m_q[0]);
    check_eq("busy", busy, m_nbits != 0);
    check_eq("overflow", overflow, m_ovf);
    check_eq("frame_err", frame_err, m_ferr);
  endtask

  // One clock cycle: compare, then drive this cycle's inputs.
  task automatic step(input bit st, input bit s, input bit rdy, input bit clr);
    @(negedge clk);
    check_outputs();
    start      = st;
    sin        = s;
    dout_ready = rdy;
    clr_err    = clr;
    model_step(st, s, rdy, clr);
  endtask

  task automatic send(input logic [W-1:0] word, input int nb, input bit rdy);
    for (int i = 0; i < nb; i++) step(i == 0, word[W-1-i], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy, input bit clr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, clr);
  endtask

  task automatic reset_async();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_dout", dout, 0);
    check_eq("arst_dout_valid", dout_valid, 0);
    check_eq("arst_level", level, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_overflow", overflow, 0);
    check_eq("arst_frame_err", frame_err, 0);
    model_reset();
    start = 1'b0; sin = 1'b0; dout_ready = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int bias;
    rst_n = 1'b0; start = 1'b0; sin = 1'b0; dout_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dout", dout, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word with consumer ready.
    send(16'hA5C3, W, 1'b1);
    idle(4, 1'b1, 1'b0);

    // Back-to-back into a stalled consumer: third word dropped.
    send(16'h1234, W, 1'b0);
    send(16'hFFFF, W, 1'b0);
    send(16'h0001, W, 1'b0);
    idle(2, 1'b0, 1'b0);
    check_eq("t2_overflow", overflow, 1);
    check_eq("t2_level", level, 2);
    idle(4, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b1);

    // Push and pop together at full.
    send(16'h1111, W, 1'b0);
    send(16'h2222, W, 1'b0);
    send(16'h3333, W, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);
    check_eq("t3_overflow", overflow, 0);
    check_eq("t3_level", level, 2);
    idle(4, 1'b1, 1'b0);

    // Frame abort then clear.
    send(16'h00FF, 8, 1'b1);
    send(16'hBEEF, W, 1'b1);
    idle(3, 1'b1, 1'b0);
    check_eq("t4_frame_err", frame_err, 1);
    idle(1, 1'b1, 1'b1);
    idle(1, 1'b1, 1'b0);
    check_eq("t4_frame_err_clr", frame_err, 0);

    // Asynchronous reset mid-word with one word queued.
    send(16'h4242, W, 1'b0);
    idle(1, 1'b0, 1'b0);
    send(16'h5555, 9, 1'b0);
    reset_async();
    send(16'h8001, W, 1'b1);
    idle(3, 1'b1, 1'b0);

    // Clear in the same cycle as a drop: set wins.
    send(16'hAAAA, W, 1'b0);
    send(16'hBBBB, W, 1'b0);
    send(16'hCCCC, W, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b0);
    check_eq("t6_overflow", overflow, 1);
    idle(4, 1'b1, 1'b1);

    // Randomized traffic.
    bias = 2;
    for (int n = 0; n < 3000; n++) begin
      bit st;
      if (n % 200 == 0) bias = $urandom_range(0, 4);
      if (n == 1500) reset_async();
      st = (m_nbits == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      step(st, 1'($urandom), $urandom_range(0, 3) < bias, $urandom_range(0, 39) == 0);
    end
    idle(2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shiftreg_sipo_deframer.md
Name: shiftreg_sipo_deframer

Overview:
- Serial-in, parallel-out receiver directly downstream of the 16-bit PISO shift register.
- Samples the serial stream MSB-first, starting on a start strobe aligned to the first bit, and assembles WIDTH-bit words.
- Pushes completed words into a small output FIFO with a valid/ready handshake toward the consuming logic.
- Reports dropped words (FIFO full) and aborted frames (start during assembly) through sticky error flags.

Parameters:
WIDTH, 16, bits per serial word; must be ≥2.
DEPTH, 2, output FIFO entries; power of two, ≥2.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  reset; asynchronous and active-low.
sin  input  1  serial data, MSB first.
start  input  1  high in the cycle the MSB of a new word is on sin.
dout  output  WIDTH  head-of-FIFO word; valid only while dout_valid=1.
dout_valid  output  1  FIFO non-empty.
dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready.
level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
busy  output  1  word assembly in progress (state SHIFT).
overflow  output  1  sticky: completed word dropped because FIFO full.
frame_err  output  1  sticky: start arrived mid-word.
clr_err  input  1  clears overflow and frame_err next edge.

Behaviour:
- Reset (rst_n=0, async):
  - State IDLE; bit counter 0; shift register 0.
  - FIFO empty: level=0, dout_valid=0, dout=0.
  - busy=0, overflow=0, frame_err=0.
  - Reset mid-word discards the partial word and all FIFO contents.
- FSM, states IDLE and SHIFT:
  - IDLE, start=1: sample sin as bit WIDTH-1, counter←1, go to SHIFT.
  - IDLE, start=0: sin ignored.
  - SHIFT, start=0: shift sin into LSB (shreg←{shreg[WIDTH-2:0],sin}), counter+1.
  - SHIFT, counter=WIDTH-1: the sample completes the word. Raise a registered push request; state→IDLE.
  - SHIFT, start=1: partial word discarded, frame_err←1. This cycle's sin is taken as the MSB of the new word; counter←1; stay in SHIFT.
- busy=1 exactly in SHIFT.
- Latency:
  - MSB sampled at cycle 0, LSB at cycle WIDTH-1.
  - Push occurs at the edge ending cycle WIDTH. dout_valid rises in cycle WIDTH+1 if the FIFO was empty.
- Back-to-back words: start is legal in the cycle immediately after the LSB cycle (state IDLE). No gap cycles are required, and push of the previous word proceeds in parallel.
- FIFO:
  - Pop when dout_valid & dout_ready.
  - Push is accepted if level<DEPTH, or if level=DEPTH and a pop occurs in the same cycle.
  - Otherwise the new word is dropped, overflow←1, and FIFO contents are unchanged.
  - Simultaneous push+pop leaves level unchanged. Ordering is strictly FIFO.
  - Pointers wrap modulo DEPTH.
  - dout is combinational from the head entry and is stable while dout_valid=1 and dout_ready=0.
- Error flags:
  - overflow and frame_err hold until clr_err=1 or reset.
  - If clr_err and a new error event occur in the same cycle, the set wins (flag=1).
- dout_ready while empty has no effect. level never exceeds DEPTH or underflows.

Test Plan:
1. Single word: start at cycle 0, sin = 0xA5C3 MSB-first over cycles 0–15, dout_ready=1 → dout_valid=1 with dout=0xA5C3 in cycle 17 (one-cycle pulse); busy high cycles 1–15; level returns to 0.
2. Back-to-back with dout_ready=0: words 0x1234, 0xFFFF, 0x0001 sent with no gaps → level=2 after the second word; third word dropped, overflow=1. Then dout_ready=1 pops 0x1234 then 0xFFFF; level=0.
3. Simultaneous push/pop at full: FIFO holds 0x1111, 0x2222; dout_ready=1 in the third word's push cycle → 0x3333 accepted, level stays 2, overflow stays 0. Output order is 0x1111, 0x2222, 0x3333.
4. Frame abort: start, 7 bits of 0x00FF, then start with 0xBEEF → frame_err=1; only 0xBEEF delivered. clr_err=1 for one cycle → frame_err=0.
5. Async reset mid-word: rst_n low at bit 9 of 0x5555 while the FIFO holds one word → all outputs 0 immediately, without waiting for a clk edge. After release, a fresh word 0x8001 is received correctly.
6. Error priority: clr_err=1 in the same cycle as an overflow drop → overflow reads 1 afterwards.
